// File: rtl/plot_scheduler.sv
// Arbitrates four players' plot requests round-robin onto one VGA write port,
// and can repaint the whole screen pixel by pixel on request.
module plot_scheduler #(
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [14:0] p1,
    input  logic [14:0] p2,
    input  logic [14:0] p3,
    input  logic [14:0] p4,
    input  logic        clear_start,
    output logic [3:0]  grant,
    output logic        busy_clear,
    output logic        clear_done,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);
    localparam int XW = (X_MAX > 0) ? $clog2(X_MAX + 1) : 1;
    localparam int YW = (Y_MAX > 0) ? $clog2(Y_MAX + 1) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_MAX);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    grant_q, grant_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;

    logic [3:0]  elig;
    logic [1:0]  cand;
    logic [1:0]  pick;
    logic        found;
    logic [14:0] sel_pos;
    logic [2:0]  sel_colour;
    logic        pix_ok;

    // A player granted this cycle is masked so it cannot be served twice in a row.
    always_comb begin
        elig  = req & ~grant_q;
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        case (pick)
            2'd0:    begin sel_pos = p1; sel_colour = 3'b001; end
            2'd1:    begin sel_pos = p2; sel_colour = 3'b010; end
            2'd2:    begin sel_pos = p3; sel_colour = 3'b100; end
            default: begin sel_pos = p4; sel_colour = 3'b110; end
        endcase
        pix_ok = (int'(sel_pos[14:7]) <= X_MAX) && (int'(sel_pos[6:0]) <= Y_MAX);
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = 4'b0000;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        case (state_q)
            CLEAR: begin
                if (cx_q == X_LAST && cy_q == Y_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cx_d    = '0;
                    cy_d    = '0;
                end else begin
                    if (cx_q == X_LAST) begin
                        cx_d = '0;
                        cy_d = cy_q + YW'(1);
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    x_d      = 8'(cx_d);
                    y_d      = 7'(cy_d);
                    colour_d = CLEAR_COLOUR;
                end
            end
            default: begin
                state_d = IDLE;
                if (clear_start) begin
                    state_d  = CLEAR;
                    cx_d     = '0;
                    cy_d     = '0;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    x_d      = 8'd0;
                    y_d      = 7'd0;
                    colour_d = CLEAR_COLOUR;
                end else if (found) begin
                    // Off-screen positions still consume the grant and move the pointer.
                    state_d = SERVE;
                    last_d  = pick;
                    grant_d = 4'b0001 << pick;
                    if (pix_ok) begin
                        plot_d   = 1'b1;
                        x_d      = sel_pos[14:7];
                        y_d      = sel_pos[6:0];
                        colour_d = sel_colour;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 2'd3;
            grant_q  <= 4'b0000;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'b000;
            cx_q     <= '0;
            cy_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
        end
    end

    assign grant      = grant_q;
    assign plot       = plot_q;
    assign busy_clear = busy_q;
    assign clear_done = done_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
endmodule

// File: tb/tb_plot_scheduler.sv
// Scoreboard bench for plot_scheduler: a transaction-level model predicts every
// output event with its cycle number, and a negedge monitor compares them.
module tb_plot_scheduler;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;
    localparam int NPIX  = (X_MAX + 1) * (Y_MAX + 1);

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [14:0] p1, p2, p3, p4;
    logic        clear_start;
    logic [3:0]  grant;
    logic        busy_clear, clear_done, plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;

    plot_scheduler #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .CLEAR_COLOUR(3'b000)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .req(req),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .clear_start(clear_start),
        .grant(grant), .busy_clear(busy_clear), .clear_done(clear_done),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         tag;
        logic [3:0] grant;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         last_idx = 3;
    logic [3:0] model_grant = 4'b0000;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [14:0] pos_of(input int i);
        case (i)
            0:       return p1;
            1:       return p2;
            2:       return p3;
            default: return p4;
        endcase
    endfunction

    function automatic logic [2:0] colour_of(input int i);
        case (i)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b110;
        endcase
    endfunction

    // Predicts what the edge after this call produces for inputs (r, cs).
    task automatic model_edge(input logic [3:0] r, input logic cs);
        exp_t        e;
        logic [3:0]  elig;
        logic [14:0] pos;
        int          idx;
        bit          found;
        if (cs) begin
            for (int yy = 0; yy <= Y_MAX; yy++) begin
                for (int xx = 0; xx <= X_MAX; xx++) begin
                    e.tag = cyc + 1 + yy * (X_MAX + 1) + xx;
                    e.grant = 4'b0000; e.plot = 1'b1; e.x = 8'(xx); e.y = 7'(yy);
                    e.colour = 3'b000; e.busy = 1'b1; e.done = 1'b0;
                    sb.push_back(e);
                end
            end
            e.tag = cyc + 1 + NPIX;
            e.grant = 4'b0000; e.plot = 1'b0; e.x = 8'd0; e.y = 7'd0;
            e.colour = 3'b000; e.busy = 1'b0; e.done = 1'b1;
            sb.push_back(e);
            model_grant = 4'b0000;
        end else begin
            elig = r & ~model_grant;
            model_grant = 4'b0000;
            found = 0;
            idx = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && elig[(last_idx + k) % 4]) begin
                    found = 1;
                    idx = (last_idx + k) % 4;
                end
            end
            if (found) begin
                pos = pos_of(idx);
                e.tag = cyc + 1;
                e.grant = 4'b0000;
                e.grant[idx] = 1'b1;
                e.plot = (int'(pos[14:7]) <= X_MAX) && (int'(pos[6:0]) <= Y_MAX);
                e.x = pos[14:7]; e.y = pos[6:0]; e.colour = colour_of(idx);
                e.busy = 1'b0; e.done = 1'b0;
                sb.push_back(e);
                model_grant = e.grant;
                last_idx = idx;
            end
        end
    endtask

    task automatic check_output(input string name, input exp_t e);
        bit bad;
        vectors++;
        bad = (grant !== e.grant) || (plot !== e.plot) || (busy_clear !== e.busy) || (clear_done !== e.done);
        if (e.plot) bad = bad || (x !== e.x) || (y !== e.y) || (colour !== e.colour);
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d: got grant=%b plot=%b x=%0d y=%0d colour=%b busy=%b done=%b, expected grant=%b plot=%b x=%0d y=%0d colour=%b busy=%b done=%b",
                     name, cyc, grant, plot, x, y, colour, busy_clear, clear_done,
                     e.grant, e.plot, e.x, e.y, e.colour, e.busy, e.done);
        end
    endtask

    always @(negedge CLOCK_50) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tag < cyc) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_event tag=%0d: got no output, expected grant=%b plot=%b done=%b",
                     e.tag, e.grant, e.plot, e.done);
        end
        if (sb.size() > 0 && sb[0].tag == cyc) begin
            e = sb.pop_front();
            check_output("event", e);
        end else if (grant != 4'b0000 || plot || busy_clear || clear_done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_event cyc=%0d: got grant=%b plot=%b busy=%b done=%b, expected all 0",
                     cyc, grant, plot, busy_clear, clear_done);
        end
    end

    task automatic check_all_zero(input string name);
        vectors++;
        if (grant !== 4'b0000 || plot !== 1'b0 || busy_clear !== 1'b0 || clear_done !== 1'b0 ||
            x !== 8'd0 || y !== 7'd0 || colour !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL %s: got grant=%b plot=%b busy=%b done=%b x=%0d y=%0d colour=%b, expected all 0",
                     name, grant, plot, busy_clear, clear_done, x, y, colour);
        end
    endtask

    // Called at posedge+2; drives inputs for the next edge and leaves at posedge+2.
    task automatic apply_stimulus(input logic [3:0] r, input logic cs);
        req = r;
        clear_start = cs;
        model_edge(r, cs);
        @(posedge CLOCK_50); #2;
        if (cs) begin
            clear_start = 1'b0;
            repeat (NPIX) @(posedge CLOCK_50);
            #2;
        end
    endtask

    task automatic random_positions();
        p1 = {8'($urandom_range(0, 199)), 7'($urandom_range(0, 127))};
        p2 = {8'($urandom_range(0, 199)), 7'($urandom_range(0, 127))};
        p3 = {8'($urandom_range(0, 199)), 7'($urandom_range(0, 127))};
        p4 = {8'($urandom_range(0, 199)), 7'($urandom_range(0, 127))};
    endtask

    task automatic run_req(input int n, input logic [3:0] start, input int new_pct,
                           input int keep_pct, input bit randpos);
        logic [3:0] pend;
        pend = start;
        for (int c = 0; c < n; c++) begin
            if (randpos) random_positions();
            for (int i = 0; i < 4; i++)
                if (!pend[i] && $urandom_range(0, 99) < new_pct) pend[i] = 1'b1;
            apply_stimulus(pend, 1'b0);
            for (int i = 0; i < 4; i++)
                if (model_grant[i] && $urandom_range(0, 99) >= keep_pct) pend[i] = 1'b0;
        end
    endtask

    task automatic reset_mid_sweep();
        int target;
        req = 4'b0000;
        clear_start = 1'b1;
        model_edge(4'b0000, 1'b1);
        target = cyc + 1 + 60 * (X_MAX + 1) + 40;
        @(posedge CLOCK_50); #2;
        clear_start = 1'b0;
        while (cyc < target) begin
            @(posedge CLOCK_50); #2;
        end
        @(negedge CLOCK_50); #1;
        reset = 1'b1;
        sb.delete();
        last_idx = 3;
        model_grant = 4'b0000;
        #1;
        check_all_zero("reset_mid_sweep");
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(posedge CLOCK_50); #2;
    endtask

    initial begin
        #(95000 * 10);
        $display("[TB] FAIL timeout: got no finish, expected finish before cycle 95000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req = 4'b0000;
        clear_start = 1'b0;
        p1 = {8'd1, 7'd2}; p2 = {8'd3, 7'd4}; p3 = {8'd5, 7'd6}; p4 = {8'd7, 7'd8};
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_all_zero("reset_state");
        reset = 1'b0;
        @(posedge CLOCK_50); #2;

        apply_stimulus(4'b0000, 1'b0);
        run_req(5, 4'b1111, 0, 0, 0);

        p1 = {8'd10, 7'd20};
        run_req(8, 4'b0001, 0, 100, 0);

        p2 = {8'd200, 7'd5};
        run_req(2, 4'b0010, 0, 0, 0);

        p3 = {8'd30, 7'd40};
        apply_stimulus(4'b0100, 1'b1);
        run_req(2, 4'b0100, 0, 0, 0);

        run_req(300, 4'b0000, 30, 40, 1);

        reset_mid_sweep();
        apply_stimulus(4'b0000, 1'b0);
        apply_stimulus(4'b0000, 1'b0);
        apply_stimulus(4'b1000, 1'b1);
        run_req(200, 4'b1000, 35, 30, 1);

        run_req(4, 4'b0000, 0, 0, 0);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d outstanding events, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/plot_scheduler.md
PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 Parameter X_MAX, default 159, SHALL give the last valid x coordinate.
REQ-002 Parameter Y_MAX, default 119, SHALL give the last valid y coordinate.
REQ-003 Parameter CLEAR_COLOUR, default 3'b000, SHALL give the colour written during a screen clear.
REQ-004 CLOCK_50  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 req  in  4  SHALL carry per-player plot requests; bit i = player i+1; held high until granted.
REQ-007 p1, p2, p3, p4  in  15 each  SHALL carry player positions packed as {x[7:0], y[6:0]}.
REQ-008 clear_start  in  1  SHALL be a single-cycle request to repaint the whole screen.
REQ-009 grant  out  4  SHALL be a one-hot, one-cycle acknowledge of the served request.
REQ-010 busy_clear  out  1  SHALL be high while a screen sweep is in progress.
REQ-011 clear_done  out  1  SHALL be a one-cycle pulse when a sweep completes.
REQ-012 x  out  8, y  out  7, colour  out  3, plot  out  1  SHALL drive the VGA adapter write port.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states SHALL be IDLE, SERVE, CLEAR and DONE.
REQ-015 IDLE/SERVE: state SHALL be SERVE in a cycle that drives a grant, otherwise IDLE.
REQ-016 In IDLE/SERVE with any eligible req and clear_start low, the block SHALL pick one requester round-robin, starting from the player after the last granted one.
REQ-017 At that edge the block SHALL set grant[i]=1, {x,y} from p(i+1), and plot=1; latency = 1 cycle from req sampled to plot.
REQ-018 Colours SHALL be fixed: p1 3'b001, p2 3'b010, p3 3'b100, p4 3'b110.
REQ-019 A req bit whose grant bit is high in the current cycle SHALL be excluded from arbitration that cycle (no double grant); other players may be served back-to-back.
REQ-020 If the selected position has x>X_MAX or y>Y_MAX, the block SHALL still issue the grant, hold plot=0, and advance the pointer.
REQ-021 With no eligible req, grant and plot SHALL be 0; x, y and colour SHALL hold their values.
REQ-022 clear_start sampled high in IDLE/SERVE SHALL enter CLEAR and win over any same-cycle req; pending reqs SHALL stay pending with no grant.
REQ-023 CLEAR SHALL emit one pixel per cycle with plot=1 and colour=CLEAR_COLOUR: x 0..X_MAX inner, y 0..Y_MAX outer.
REQ-024 Pixel (0,0) SHALL appear the cycle after clear_start is sampled; a default sweep takes 19200 cycles.
REQ-025 busy_clear SHALL be high exactly during the sweep-pixel cycles.
REQ-026 In CLEAR, grant SHALL be 0 and clear_start SHALL be ignored.
REQ-027 After pixel (X_MAX,Y_MAX) the block SHALL enter DONE for one cycle: clear_done=1, plot=0, grant=0; IDLE follows.
REQ-028 Arbitration SHALL resume in the cycle after DONE, with the round-robin pointer unchanged by the clear.
REQ-029 Sweep counters SHALL be sized for the parameters and SHALL never produce coordinates beyond X_MAX/Y_MAX.

Reset
REQ-030 Asserting reset SHALL immediately force state IDLE; grant, plot, busy_clear, clear_done, x, y, colour = 0; sweep counters 0.
REQ-031 After reset, the round-robin pointer SHALL give p1 highest priority.
REQ-032 reset during CLEAR SHALL abort the sweep with no clear_done pulse.
REQ-033 On reset release, no grant or plot SHALL be issued before the first edge that samples a req.

Verification
REQ-034 After reset, req=4'b1111 held, each player deasserting on its grant -> grants 0001, 0010, 0100, 1000 on consecutive cycles; colours 001, 010, 100, 110.
REQ-035 req=4'b0001 held continuously, p1={8'd10,7'd20} -> grant[0] on alternate cycles; x=10, y=20, plot=1 in each grant cycle.
REQ-036 p2={8'd200,7'd5}, req=4'b0010 -> grant=0010, plot=0.
REQ-037 clear_start plus req=4'b0100 in the same cycle -> sweep (0,0)..(159,119) over 19200 cycles, colour 000, no grant; clear_done 1 cycle; grant=0100 the cycle after DONE.
REQ-038 reset pulse at sweep pixel (40,60) -> all outputs 0 immediately, no clear_done; a new clear_start restarts the sweep at (0,0).
